// File: rtl/bram_port_arbiter_pkg.sv
// Shared constants for the BRAM port arbiter: arbitration modes, Kyber phase-owner
// channel codes and a width helper used to size channel indices.
package bram_port_arbiter_pkg;

    localparam int MODE_PHASE = 0;
    localparam int MODE_RR    = 1;

    localparam int CH_ACCEPT  = 0;
    localparam int CH_ROUND   = 1;
    localparam int CH_OUTPUT  = 2;

    // ceil(log2(n)), but never below 1 so a channel index always has a bit.
    function automatic int clog2_min1(input int n);
        int r;
        r = 1;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant with the search starting one past the last
// winner; the pointer only moves when something is granted.
module rr_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CHW    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req_i,
    output logic [NUM_CH-1:0] gnt_o
);

    logic [CHW-1:0] ptr_q;
    logic [CHW-1:0] ptr_d;
    int             idx;

    // Walk offsets from farthest to nearest so the nearest requester wins last.
    always_comb begin
        gnt_o = '0;
        ptr_d = ptr_q;
        idx   = 0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = (int'(ptr_q) + k) % NUM_CH;
            if (req_i[idx]) begin
                gnt_o      = '0;
                gnt_o[idx] = 1'b1;
                ptr_d      = CHW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= CHW'(NUM_CH - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Single-port BRAM access multiplexer for NUM_CH clients with phase-owned or
// round-robin grant, registered BRAM outputs and tagged read-data return.
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int  NUM_CH = 4,
    parameter int  AW     = 6,
    parameter int  DW     = 64,
    parameter int  RD_LAT = 1,
    parameter int  MODE   = MODE_PHASE,
    localparam int CHW    = clog2_min1(NUM_CH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CHW-1:0]       phase_owner,
    input  logic                 phase_valid,
    input  logic [NUM_CH-1:0]    ch_req,
    input  logic [NUM_CH-1:0]    ch_we,
    input  logic [NUM_CH*AW-1:0] ch_addr,
    input  logic [NUM_CH*DW-1:0] ch_wdata,
    output logic [NUM_CH-1:0]    ch_gnt,
    output logic [NUM_CH-1:0]    ch_rvalid,
    output logic [DW-1:0]        ch_rdata,
    output logic                 bram_en,
    output logic                 bram_we,
    output logic [AW-1:0]        bram_addr,
    output logic [DW-1:0]        bram_wdata,
    input  logic [DW-1:0]        bram_rdata
);

    localparam int TAG_W = (RD_LAT + 1) * NUM_CH;

    logic                 any_gnt;
    logic                 sel_we;
    logic [AW-1:0]        sel_addr;
    logic [DW-1:0]        sel_wdata;
    logic [NUM_CH-1:0]    tag_d;

    logic                 en_q,    en_d;
    logic                 we_q,    we_d;
    logic [AW-1:0]        addr_q,  addr_d;
    logic [DW-1:0]        wdata_q, wdata_d;
    logic [TAG_W-1:0]     tag_q;

    generate
        if (MODE == MODE_RR) begin : g_rr
            logic unused_phase;
            assign unused_phase = ^{phase_owner, phase_valid};

            rr_arbiter #(
                .NUM_CH (NUM_CH),
                .CHW    (CHW)
            ) u_rr (
                .clk   (clk),
                .rst_n (rst_n),
                .req_i (ch_req),
                .gnt_o (ch_gnt)
            );
        end else begin : g_phase
            // An out-of-range owner code behaves like an idle phase.
            always_comb begin
                ch_gnt = '0;
                if (phase_valid && (int'(phase_owner) < NUM_CH)) begin
                    ch_gnt[phase_owner] = ch_req[phase_owner];
                end
            end
        end
    endgenerate

    // Grant is one-hot, so OR-ing the masked fields is a plain mux.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_gnt[i]) begin
                sel_we    = sel_we    | ch_we[i];
                sel_addr  = sel_addr  | ch_addr[i*AW +: AW];
                sel_wdata = sel_wdata | ch_wdata[i*DW +: DW];
            end
        end
    end

    assign any_gnt = |ch_gnt;
    assign en_d    = any_gnt;
    assign we_d    = any_gnt & sel_we;
    assign addr_d  = sel_addr;
    assign wdata_d = we_d ? sel_wdata : '0;
    assign tag_d   = (any_gnt && !sel_we) ? ch_gnt : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            tag_q   <= '0;
        end else begin
            en_q    <= en_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            tag_q   <= {tag_q[RD_LAT*NUM_CH-1:0], tag_d};
        end
    end

    assign bram_en    = en_q;
    assign bram_we    = we_q;
    assign bram_addr  = addr_q;
    assign bram_wdata = wdata_q;

    // The oldest tag stage lines up with the BRAM read data of the same access.
    assign ch_rvalid = tag_q[RD_LAT*NUM_CH +: NUM_CH];
    assign ch_rdata  = (|ch_rvalid) ? bram_rdata : '0;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: three instances (phase/RD_LAT=1, round-robin,
// phase/RD_LAT=2 with 3 channels), each behind a small BRAM model.
`timescale 1ns/1ps
module tb_bram_port_arbiter;
    import bram_port_arbiter_pkg::*;

    localparam int AW   = 6;
    localparam int DW   = 64;
    localparam int NDUT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0]       owner  [NDUT];
    logic             pvalid [NDUT];
    logic [3:0]       req    [NDUT];
    logic [3:0]       we     [NDUT];
    logic [4*AW-1:0]  addr   [NDUT];
    logic [4*DW-1:0]  wdata  [NDUT];

    logic [63:0] shadow   [NDUT][64];
    logic        sh_valid [NDUT][64];

    int checks = 0;
    int failures = 0;
    int mon_checks = 0;
    int mon_fails = 0;
    logic mon_on = 1'b0;

    typedef struct {
        int         dut;
        logic [3:0] ch;
        logic [63:0] data;
        int         due;
    } exp_t;
    exp_t sbq[$];

    function automatic logic [63:0] init_val(input int a);
        if (a == 'h15) return 64'h0000_0000_DEAD_BEEF;
        return {16'hC0DE, 16'(a), 16'h5A5A, 16'(a)};
    endfunction

    function automatic logic [63:0] exp_data(input int k, input int a);
        return sh_valid[k][a] ? shadow[k][a] : init_val(a);
    endfunction

    for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
        localparam int NC  = (gi == 2) ? 3 : 4;
        localparam int MD  = (gi == 1) ? MODE_RR : MODE_PHASE;
        localparam int LAT = (gi == 2) ? 2 : 1;

        logic [NC-1:0] gnt;
        logic [NC-1:0] rvalid;
        logic [DW-1:0] rdata;
        logic          ben;
        logic          bwe;
        logic [AW-1:0] baddr;
        logic [DW-1:0] bwdata;
        logic [DW-1:0] brdata;
        logic [DW-1:0] mem [64];
        logic [63:0]   wr_seen;
        logic [DW-1:0] rpipe [LAT];

        bram_port_arbiter #(
            .NUM_CH (NC),
            .AW     (AW),
            .DW     (DW),
            .RD_LAT (LAT),
            .MODE   (MD)
        ) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .phase_owner (owner[gi]),
            .phase_valid (pvalid[gi]),
            .ch_req      (req[gi][NC-1:0]),
            .ch_we       (we[gi][NC-1:0]),
            .ch_addr     (addr[gi][NC*AW-1:0]),
            .ch_wdata    (wdata[gi][NC*DW-1:0]),
            .ch_gnt      (gnt),
            .ch_rvalid   (rvalid),
            .ch_rdata    (rdata),
            .bram_en     (ben),
            .bram_we     (bwe),
            .bram_addr   (baddr),
            .bram_wdata  (bwdata),
            .bram_rdata  (brdata)
        );

        // Read-first BRAM with LAT cycles from registered address to data.
        always @(posedge clk) begin
            if (!rst_n) begin
                wr_seen <= '0;
            end else if (ben && bwe) begin
                mem[baddr]     <= bwdata;
                wr_seen[baddr] <= 1'b1;
            end
            if (ben && !bwe) begin
                rpipe[0] <= wr_seen[baddr] ? mem[baddr] : init_val(int'(baddr));
            end
            for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
        end
        assign brdata = rpipe[LAT-1];
    end

    task automatic mon_dut(input int k, input logic [3:0] rv, input logic [63:0] rd);
        exp_t e;
        if (rv !== 4'b0) begin
            mon_checks++;
            if (sbq.size() == 0 || sbq[0].dut != k) begin
                mon_fails++;
                $display("FAIL rvalid_unexpected dut%0d cyc=%0d got rvalid=%b required none", k, cyc, rv);
            end else begin
                e = sbq.pop_front();
                if (rv !== e.ch || rd !== e.data || cyc != e.due) begin
                    mon_fails++;
                    $display("FAIL read_return dut%0d got rvalid=%b rdata=%h cyc=%0d required rvalid=%b rdata=%h cyc=%0d",
                             k, rv, rd, cyc, e.ch, e.data, e.due);
                end else begin
                    $display("read return dut%0d ch=%b data=%h cyc=%0d", k, rv, rd, cyc);
                end
            end
        end else begin
            if (sbq.size() != 0 && sbq[0].dut == k && cyc >= sbq[0].due) begin
                e = sbq.pop_front();
                mon_checks++;
                mon_fails++;
                $display("FAIL read_missing dut%0d cyc=%0d got rvalid=0 required rvalid=%b rdata=%h", k, cyc, e.ch, e.data);
            end
            mon_checks++;
            if (rd !== 64'h0) begin
                mon_fails++;
                $display("FAIL rdata_idle dut%0d cyc=%0d got rdata=%h required 0", k, cyc, rd);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            mon_dut(0, 4'(g_dut[0].rvalid), g_dut[0].rdata);
            mon_dut(1, 4'(g_dut[1].rvalid), g_dut[1].rdata);
            mon_dut(2, 4'(g_dut[2].rvalid), g_dut[2].rdata);
        end
    end

    task automatic clear_inputs();
        for (int k = 0; k < NDUT; k++) begin
            owner[k] = '0; pvalid[k] = 1'b0; req[k] = '0; we[k] = '0; addr[k] = '0; wdata[k] = '0;
        end
    endtask

    task automatic set_ch(input int k, input int ch, input logic w, input logic [5:0] a, input logic [63:0] d);
        req[k][ch] = 1'b1;
        we[k][ch]  = w;
        addr[k][ch*AW +: AW]  = a;
        wdata[k][ch*DW +: DW] = d;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_read(input int k, input int ch, input logic [5:0] a, input int lat);
        exp_t e;
        e.dut  = k;
        e.ch   = 4'(1 << ch);
        e.data = exp_data(k, int'(a));
        e.due  = cyc + 1 + lat;
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({g_dut[0].ben, g_dut[1].ben, g_dut[2].ben, g_dut[0].bwe, g_dut[1].bwe, g_dut[2].bwe} !== 6'b0) begin
            failures++;
            $display("FAIL reset_en_we got=%b required=000000",
                     {g_dut[0].ben, g_dut[1].ben, g_dut[2].ben, g_dut[0].bwe, g_dut[1].bwe, g_dut[2].bwe});
        end
        checks++;
        if ({g_dut[0].baddr, g_dut[0].bwdata, g_dut[1].baddr, g_dut[1].bwdata, 4'(g_dut[0].rvalid)} !== '0) begin
            failures++;
            $display("FAIL reset_addr_wdata_rvalid got addr=%h wdata=%h rvalid=%b required all 0",
                     g_dut[0].baddr, g_dut[0].bwdata, g_dut[0].rvalid);
        end
        $display("reset state checked");
    endtask

    task automatic test_reset_midstream();
        next_cycle();
        pvalid[0] = 1'b1; owner[0] = 2'(CH_ACCEPT);
        set_ch(0, 0, 1'b0, 6'h01, 64'h0);
        @(negedge clk);
        checks++;
        if (g_dut[0].gnt !== 4'b0001) begin
            failures++; $display("FAIL midrst_gnt_a got=%b required=0001", g_dut[0].gnt);
        end
        next_cycle();
        set_ch(0, 0, 1'b0, 6'h02, 64'h0);
        @(negedge clk);
        checks++;
        if (g_dut[0].gnt !== 4'b0001) begin
            failures++; $display("FAIL midrst_gnt_b got=%b required=0001", g_dut[0].gnt);
        end
        next_cycle();
        clear_inputs();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({g_dut[0].ben, g_dut[0].bwe, g_dut[0].baddr, g_dut[0].bwdata, g_dut[0].rvalid} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs got en=%b we=%b addr=%h wdata=%h rvalid=%b required all 0",
                     g_dut[0].ben, g_dut[0].bwe, g_dut[0].baddr, g_dut[0].bwdata, g_dut[0].rvalid);
        end
        repeat (2) next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (g_dut[0].rvalid !== 4'b0) begin
                failures++; $display("FAIL midrst_no_rvalid cycle%0d got=%b required=0000", i, g_dut[0].rvalid);
            end
            next_cycle();
        end
        $display("mid-stream reset checked");
    endtask

    task automatic test_mode0_read();
        pvalid[0] = 1'b1; owner[0] = 2'(CH_ROUND);
        set_ch(0, 0, 1'b0, 6'h02, 64'h0);
        set_ch(0, 1, 1'b0, 6'h15, 64'hFFFF_0000_FFFF_0000);
        @(negedge clk);
        checks++;
        if (g_dut[0].gnt !== 4'b0010) begin
            failures++; $display("FAIL m0_gnt got=%b required=0010", g_dut[0].gnt);
        end
        push_read(0, 1, 6'h15, 1);
        next_cycle();
        req[0][1] = 1'b0;
        @(negedge clk);
        checks++;
        if (g_dut[0].gnt !== 4'b0000) begin
            failures++; $display("FAIL m0_nonowner_gnt got=%b required=0000", g_dut[0].gnt);
        end
        checks++;
        if ({g_dut[0].ben, g_dut[0].bwe} !== 2'b10 || g_dut[0].baddr !== 6'h15) begin
            failures++;
            $display("FAIL m0_issue got en=%b we=%b addr=%h required en=1 we=0 addr=15", g_dut[0].ben, g_dut[0].bwe, g_dut[0].baddr);
        end
        checks++;
        if (g_dut[0].bwdata !== 64'h0) begin
            failures++; $display("FAIL m0_read_wdata got=%h required=0", g_dut[0].bwdata);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (g_dut[0].rvalid !== 4'b0010 || g_dut[0].rdata !== 64'h0000_0000_DEAD_BEEF) begin
            failures++;
            $display("FAIL m0_return got rvalid=%b rdata=%h required rvalid=0010 rdata=00000000deadbeef", g_dut[0].rvalid, g_dut[0].rdata);
        end
        checks++;
        if (g_dut[0].ben !== 1'b0) begin
            failures++; $display("FAIL m0_no_issue got en=%b required=0", g_dut[0].ben);
        end
        next_cycle();
        $display("mode0 read checked");
    endtask

    task automatic test_mode0_idle();
        pvalid[0] = 1'b0; owner[0] = 2'(CH_ACCEPT);
        pvalid[2] = 1'b1; owner[2] = 2'd3;
        for (int ch = 0; ch < 4; ch++) set_ch(0, ch, 1'b0, 6'(ch), 64'h0);
        for (int ch = 0; ch < 3; ch++) set_ch(2, ch, 1'b0, 6'(ch), 64'h0);
        @(negedge clk);
        checks++;
        if (g_dut[0].gnt !== 4'b0000) begin
            failures++; $display("FAIL idle_invalid_gnt got=%b required=0000", g_dut[0].gnt);
        end
        checks++;
        if (g_dut[2].gnt !== 3'b000) begin
            failures++; $display("FAIL idle_owner_range_gnt got=%b required=000", g_dut[2].gnt);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({g_dut[0].ben, g_dut[2].ben} !== 2'b00) begin
            failures++; $display("FAIL idle_en got=%b required=00", {g_dut[0].ben, g_dut[2].ben});
        end
        next_cycle();
        $display("mode0 idle checked");
    endtask

    task automatic test_rr_fairness();
        for (int ch = 0; ch < 4; ch++) set_ch(1, ch, 1'b0, 6'(8 + ch), 64'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (g_dut[1].gnt !== 4'(1 << (i % 4))) begin
                failures++; $display("FAIL rr_rotate step%0d got=%b required=%b", i, g_dut[1].gnt, 4'(1 << (i % 4)));
            end
            push_read(1, i % 4, 6'(8 + i % 4), 1);
            if (i > 0) begin
                checks++;
                if (g_dut[1].ben !== 1'b1) begin
                    failures++; $display("FAIL rr_en_held step%0d got=%b required=1", i, g_dut[1].ben);
                end
            end
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (g_dut[1].ben !== 1'b1) begin
            failures++; $display("FAIL rr_en_last got=%b required=1", g_dut[1].ben);
        end
        repeat (3) next_cycle();
        set_ch(1, 0, 1'b0, 6'h20, 64'h0);
        set_ch(1, 3, 1'b0, 6'h23, 64'h0);
        @(negedge clk);
        checks++;
        if (g_dut[1].gnt !== 4'b0001) begin
            failures++; $display("FAIL rr_ptr_hold got=%b required=0001", g_dut[1].gnt);
        end
        push_read(1, 0, 6'h20, 1);
        next_cycle();
        @(negedge clk);
        checks++;
        if (g_dut[1].gnt !== 4'b1000) begin
            failures++; $display("FAIL rr_after_ch0 got=%b required=1000", g_dut[1].gnt);
        end
        push_read(1, 3, 6'h23, 1);
        next_cycle();
        clear_inputs();
        repeat (2) next_cycle();
        set_ch(1, 1, 1'b0, 6'h11, 64'h0);
        set_ch(1, 3, 1'b0, 6'h13, 64'h0);
        @(negedge clk);
        checks++;
        if (g_dut[1].gnt !== 4'b0010) begin
            failures++; $display("FAIL rr_wrap got=%b required=0010", g_dut[1].gnt);
        end
        push_read(1, 1, 6'h11, 1);
        next_cycle();
        clear_inputs();
        repeat (3) next_cycle();
        $display("round-robin checked");
    endtask

    task automatic test_write();
        set_ch(1, 2, 1'b1, 6'h3F, 64'h0123_4567_89AB_CDEF);
        @(negedge clk);
        checks++;
        if (g_dut[1].gnt !== 4'b0100) begin
            failures++; $display("FAIL wr_gnt got=%b required=0100", g_dut[1].gnt);
        end
        shadow[1][63]   = 64'h0123_4567_89AB_CDEF;
        sh_valid[1][63] = 1'b1;
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if ({g_dut[1].ben, g_dut[1].bwe} !== 2'b11 || g_dut[1].baddr !== 6'h3F) begin
            failures++;
            $display("FAIL wr_issue got en=%b we=%b addr=%h required en=1 we=1 addr=3f", g_dut[1].ben, g_dut[1].bwe, g_dut[1].baddr);
        end
        checks++;
        if (g_dut[1].bwdata !== 64'h0123_4567_89AB_CDEF) begin
            failures++; $display("FAIL wr_wdata got=%h required=0123456789abcdef", g_dut[1].bwdata);
        end
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            @(negedge clk);
            checks++;
            if (g_dut[1].rvalid !== 4'b0) begin
                failures++; $display("FAIL wr_no_rvalid cycle%0d got=%b required=0000", i, g_dut[1].rvalid);
            end
        end
        next_cycle();
        set_ch(1, 1, 1'b0, 6'h3F, 64'h0);
        @(negedge clk);
        checks++;
        if (g_dut[1].gnt !== 4'b0010) begin
            failures++; $display("FAIL wr_readback_gnt got=%b required=0010", g_dut[1].gnt);
        end
        push_read(1, 1, 6'h3F, 1);
        next_cycle();
        clear_inputs();
        repeat (3) next_cycle();
        $display("write checked");
    endtask

    task automatic test_owner_switch();
        pvalid[2] = 1'b1; owner[2] = 2'(CH_ACCEPT);
        set_ch(2, 0, 1'b0, 6'h05, 64'h0);
        @(negedge clk);
        checks++;
        if (g_dut[2].gnt !== 3'b001) begin
            failures++; $display("FAIL sw_gnt_ch0 got=%b required=001", g_dut[2].gnt);
        end
        push_read(2, 0, 6'h05, 2);
        next_cycle();
        owner[2] = 2'(CH_OUTPUT);
        set_ch(2, 0, 1'b0, 6'h07, 64'h0);
        set_ch(2, 2, 1'b0, 6'h06, 64'h0);
        @(negedge clk);
        checks++;
        if (g_dut[2].gnt !== 3'b100) begin
            failures++; $display("FAIL sw_gnt_ch2 got=%b required=100", g_dut[2].gnt);
        end
        push_read(2, 2, 6'h06, 2);
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (g_dut[2].rvalid !== 3'b000) begin
            failures++; $display("FAIL sw_early got=%b required=000", g_dut[2].rvalid);
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (g_dut[2].rvalid !== 3'b001 || g_dut[2].rdata !== init_val('h05)) begin
            failures++; $display("FAIL sw_ret_ch0 got rvalid=%b rdata=%h required rvalid=001 rdata=%h", g_dut[2].rvalid, g_dut[2].rdata, init_val('h05));
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (g_dut[2].rvalid !== 3'b100 || g_dut[2].rdata !== init_val('h06)) begin
            failures++; $display("FAIL sw_ret_ch2 got rvalid=%b rdata=%h required rvalid=100 rdata=%h", g_dut[2].rvalid, g_dut[2].rdata, init_val('h06));
        end
        next_cycle();
        $display("owner switch checked");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            for (int a = 0; a < 64; a++) begin
                shadow[k][a]   = 64'h0;
                sh_valid[k][a] = 1'b0;
            end
        end
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        mon_on = 1'b1;

        test_reset();
        test_reset_midstream();
        test_mode0_read();
        test_mode0_idle();
        test_rr_fairness();
        test_write();
        test_owner_switch();

        repeat (4) next_cycle();
        checks++;
        if (sbq.size() != 0) begin
            failures++; $display("FAIL scoreboard_drain got=%0d pending required=0", sbq.size());
        end
        @(negedge clk);
        checks   = checks + mon_checks;
        failures = failures + mon_fails;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
